// File: rtl/rx_serial_pkg.sv
// Shared types and defaults for the serial receiver front end.
// Used by rx_serial_amostrador and its synchroniser.
package rx_serial_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    ALINHA = 2'b01,
    CONTA  = 2'b10,
    FIM    = 2'b11
  } estado_t;

  localparam int DIVISOR_PADRAO    = 434;
  localparam int FRAME_BITS_PADRAO = 10;

  function automatic logic maioria3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_serial_sincronizador.sv
// Two-flop synchroniser for the asynchronous RX line.
// Both flops reset to 1 so an idle line is seen during and right after reset.
module rx_serial_sincronizador (
  input  logic clock,
  input  logic reset,
  input  logic rx_i,
  output logic rx_sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
    end
  end

  assign rx_sync_o = sync_q;

endmodule

// File: rtl/rx_serial_amostrador.sv
// Serial receiver sampler: emits one tick per frame bit at its centre after zera_tick.
// Define RX_MAJORITY_EN for 2-of-3 majority sampling (ticks move one cycle later).
module rx_serial_amostrador
  import rx_serial_pkg::*;
#(
  parameter int DIVISOR    = DIVISOR_PADRAO,
  parameter int FRAME_BITS = FRAME_BITS_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RX,
  input  logic       zera_tick,
  output logic       rx_sync,
  output logic       tick,
  output logic       rx_amostrado,
  output logic       fim,
  output logic       erro_inicio,
  output logic [1:0] db_estado
);

  localparam int BAUD_W = $clog2(DIVISOR);
  localparam int BIT_W  = $clog2(FRAME_BITS + 1);
`ifdef RX_MAJORITY_EN
  localparam int ATRASO = 1;
`else
  localparam int ATRASO = 0;
`endif
  // Baud counter is 0 in the cycle after zera_tick or after a tick.
  localparam logic [BAUD_W-1:0] META_ALINHA = BAUD_W'(DIVISOR / 2 - 1 + ATRASO);
  localparam logic [BAUD_W-1:0] META_CONTA  = BAUD_W'(DIVISOR - 1);
  localparam logic [BIT_W-1:0]  ULTIMO_BIT  = BIT_W'(FRAME_BITS - 1);

  estado_t           estado_q, estado_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bits_q, bits_d;
  logic              fim_q, fim_d;
  logic              erro_q, erro_d;
  logic              amost_q, amost_d;
  logic              amostra;

  rx_serial_sincronizador u_sincronizador (
    .clock     (clock),
    .reset     (reset),
    .rx_i      (RX),
    .rx_sync_o (rx_sync)
  );

`ifdef RX_MAJORITY_EN
  logic [1:0] hist_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hist_q <= 2'b11;
    else       hist_q <= {hist_q[0], rx_sync};
  end

  assign amostra = maioria3(hist_q[1], hist_q[0], rx_sync);
`else
  assign amostra = rx_sync;
`endif

  always_comb begin
    estado_d = estado_q;
    baud_d   = baud_q;
    bits_d   = bits_q;
    fim_d    = fim_q;
    erro_d   = erro_q;
    amost_d  = amost_q;
    tick     = 1'b0;

    case (estado_q)
      ALINHA: begin
        if (baud_q == META_ALINHA) begin
          if (!amostra) begin
            tick     = 1'b1;
            amost_d  = 1'b0;
            bits_d   = BIT_W'(1);
            baud_d   = '0;
            estado_d = CONTA;
          end else begin
            erro_d   = 1'b1;
            fim_d    = 1'b1;
            estado_d = FIM;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      CONTA: begin
        if (baud_q == META_CONTA) begin
          tick    = 1'b1;
          amost_d = amostra;
          bits_d  = bits_q + 1'b1;
          baud_d  = '0;
          if (bits_q == ULTIMO_BIT) begin
            fim_d    = 1'b1;
            estado_d = FIM;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: ;
    endcase

    // A restart overrides whatever the current state was doing, including a due tick.
    if (zera_tick) begin
      tick     = 1'b0;
      amost_d  = amost_q;
      baud_d   = '0;
      bits_d   = '0;
      fim_d    = 1'b0;
      erro_d   = 1'b0;
      estado_d = ALINHA;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      baud_q   <= '0;
      bits_q   <= '0;
      fim_q    <= 1'b0;
      erro_q   <= 1'b0;
      amost_q  <= 1'b1;
    end else begin
      estado_q <= estado_d;
      baud_q   <= baud_d;
      bits_q   <= bits_d;
      fim_q    <= fim_d;
      erro_q   <= erro_d;
      amost_q  <= amost_d;
    end
  end

  assign rx_amostrado = tick ? amostra : amost_q;
  assign fim          = fim_q;
  assign erro_inicio  = erro_q;
  assign db_estado    = estado_q;

endmodule
